bennett_phase_clock: RTL and testbench
======================================

Name: bennett_phase_clock

Overview:
- Multi-phase Bennett-style clock generator for the adiabatic processor.
- Derives PHASES trapezoid-free digital phase clocks from one system clock. Phases rise in ascending order (0 to PHASES-1), then fall in descending order (PHASES-1 to 0). This is the retractile "compute then uncompute" sequence required by reversible logic stages such as the SRAM bank and its 2-port write driver.
- Also emits a master clock and an instruction-boundary flag. Downstream logic consumes phases individually; inverted phases are produced outside this block.

Parameters:
- PHASES, 10, number of phase clocks; legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clkp  output  PHASES  phase clocks; bit i is phase i.
- Mclk  output  1  master clock; high during the ramp-up half of each Bennett cycle.
- instFlag  output  1  one-clk pulse marking the instruction boundary, when all phases are low.

Behaviour:
- Internal step counter s, width clog2(2*PHASES).
  - Counts 0 .. 2*PHASES-1 and wraps to 0.
  - Advances by 1 on every rising clk edge while reset is high.
- Bennett cycle length: 2*PHASES clk cycles. At PHASES=10 this is 20 cycles, or 200 ns at a 10 ns clk.
- Phase decode, with N = PHASES: clkp[i] = 1 iff i <= s <= 2N-2-i.
  - Rise order: phase i rises at step s = i.
  - Fall order: phase i falls at step s = 2N-1-i.
  - Phase N-1 is high for exactly 1 cycle.
  - Phase 0 is high for 2N-1 cycles.
  - Step 2N-1 is the idle step, with all phases low.
- Nesting invariant: whenever clkp[i+1] = 1, clkp[i] = 1. No phase may be high while a lower-index phase is low.
- Mclk = 1 iff s is in 0..N-1.
- instFlag = 1 iff s = 2N-1, i.e. exactly one cycle per Bennett cycle.
- All outputs are registered: computed from the next value of s and loaded on the same edge. Outputs must be glitch-free, with no combinational decode on outputs.
- Reset (reset = 0, asynchronous):
  - s is forced to 2N-1.
  - clkp, Mclk and instFlag are forced to 0 immediately, without waiting for a clk edge.
- Reset release:
  - First rising clk edge with reset = 1 moves s to 0: clkp = 1 (only bit 0 set), Mclk = 1, instFlag = 0.
  - First instFlag pulse occurs 2N edges after release.
- Reset asserted mid-cycle: all phases drop to 0 at once, with no descending sequence enforced. After release, the sequence restarts from step 0.
- Release timing: reset deassertion is synchronous to clk. No partial step is generated.
- No other inputs. The sequence runs free and continuously.

Test Plan:
- Reset behaviour: hold reset = 0 for 2 cycles while toggling clk; also assert reset between edges -> clkp = 0, Mclk = 0 and instFlag = 0 immediately. Release -> after 1 edge clkp = 10'h001 and Mclk = 1.
- Ramp up (PHASES = 10) -> at edges 1..10 after release, clkp = 001, 003, 007, ..., 3FF, with one bit added per edge.
- Ramp down -> clkp steps 1FF, 0FF, ..., 001, then 000 at edge 20. instFlag = 1 only at edge 20. Mclk falls at edge 11.
- Periodicity -> posedge clkp[8] recurs every 20 clk (200 ns). clkp[8] is high for exactly 3 cycles, with its negedge 3 cycles after its posedge. Checker asserts the nesting invariant on every cycle.
- Mid-cycle reset: assert reset at step 7 -> all outputs 0 without a clk edge. After release the sequence restarts at step 0 with clkp = 001.
- Parameter sweep: PHASES = 2 -> sequence 01, 11, 01, 00 with period 4. instFlag fires once per period.

Source files
------------

// File: rtl/bennett_phase_clock.sv
// Bennett-style multi-phase clock generator.
// A free-running step counter walks 0 .. 2*PHASES-1. Phases rise in ascending
// order, then fall in descending order, so the phases stay nested. The last
// step is an idle step where every phase is low. That idle step also marks the
// instruction boundary.
// Every output is decoded from the *next* step value and then registered, so
// downstream reversible stages see glitch-free edges.
module bennett_phase_clock #(
  parameter int PHASES = 10
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PHASES-1:0] clkp,
  output logic              Mclk,
  output logic              instFlag
);

  localparam int              STEPS = 2 * PHASES;
  localparam int              SW    = $clog2(STEPS);
  localparam logic [SW-1:0]   LAST  = SW'(STEPS - 1);
  localparam logic [SW-1:0]   HALF  = SW'(PHASES);

  logic [SW-1:0]     r_step;
  logic [PHASES-1:0] r_clkp;
  logic              r_mclk;
  logic              r_inst_flag;

  logic [SW-1:0]     w_step_next;
  logic [PHASES-1:0] w_clkp_next;
  logic              w_mclk_next;
  logic              w_inst_flag_next;

  // Next step: count up and wrap from the idle step back to step 0.
  always_comb begin
    w_step_next = (r_step == LAST) ? '0 : r_step + SW'(1);
  end

  // Decode the next step into phase levels, the master clock and the boundary flag.
  // Phase i is high for steps i .. 2N-2-i. This makes phase i+1 a subset of phase i.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // update. No path can then leave it unassigned and infer a latch.
    w_clkp_next = '0;
    for (int i = 0; i < PHASES; i++) begin
      w_clkp_next[i] = (int'(w_step_next) >= i) && (int'(w_step_next) <= STEPS - 2 - i);
    end
    w_mclk_next      = (w_step_next < HALF);
    w_inst_flag_next = (w_step_next == LAST);
  end

  // Step counter and registered outputs. Reset parks the counter on the idle
  // step, so the first edge after release lands on step 0. Reset forces all
  // outputs low at once, even though the idle step would raise the boundary flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples the pre-edge values, whatever order the statements are in.
      r_step      <= LAST;
      r_clkp      <= '0;
      r_mclk      <= 1'b0;
      r_inst_flag <= 1'b0;
    end else begin
      r_step      <= w_step_next;
      r_clkp      <= w_clkp_next;
      r_mclk      <= w_mclk_next;
      r_inst_flag <= w_inst_flag_next;
    end
  end

  assign clkp     = r_clkp;
  assign Mclk     = r_mclk;
  assign instFlag = r_inst_flag;

endmodule

// File: tb/tb_bennett_phase_clock.sv
// Testbench for bennett_phase_clock. It runs two instances side by side:
// PHASES=10 and PHASES=2.
// The stimulus process queues the expected outputs for each clock edge. A
// separate monitor on the falling edge pops each entry and compares it. The
// monitor also checks that the phases stay nested on every cycle.
`timescale 1ns/1ps
module tb_bennett_phase_clock;

  logic       clk;
  logic       reset;
  logic [9:0] c10;
  logic       m10;
  logic       f10;
  logic [1:0] c2;
  logic       m2;
  logic       f2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         edge_no;
    logic [9:0] clkp10;
    logic       mclk10;
    logic       flag10;
    logic [1:0] clkp2;
    logic       mclk2;
    logic       flag2;
  } exp_t;

  exp_t exp_q[$];

  // Expected phase patterns, worked out by hand from the phase rule.
  localparam logic [9:0] TBL10 [20] = '{
    10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F, 10'h0FF,
    10'h1FF, 10'h3FF, 10'h1FF, 10'h0FF, 10'h07F, 10'h03F, 10'h01F, 10'h00F,
    10'h007, 10'h003, 10'h001, 10'h000
  };
  localparam logic [1:0] TBL2 [4] = '{2'b01, 2'b11, 2'b01, 2'b00};

  bennett_phase_clock #(.PHASES(10)) dut10 (
    .clk      (clk),
    .reset    (reset),
    .clkp     (c10),
    .Mclk     (m10),
    .instFlag (f10)
  );

  bennett_phase_clock #(.PHASES(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .clkp     (c2),
    .Mclk     (m2),
    .instFlag (f2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the expected outputs for n edges following a reset release.
  task automatic run_edges(input int n);
    exp_t e;
    int s10;
    int s2;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      s10       = (k - 1) % 20;
      s2        = (k - 1) % 4;
      e.edge_no = k;
      e.clkp10  = TBL10[s10];
      e.mclk10  = (s10 < 10);
      e.flag10  = (s10 == 19);
      e.clkp2   = TBL2[s2];
      e.mclk2   = (s2 < 2);
      e.flag2   = (s2 == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_clkp10"}, c10, 0);
    check({tag, "_mclk10"}, m10, 0);
    check({tag, "_flag10"}, f10, 0);
    check({tag, "_clkp2"},  c2,  0);
    check({tag, "_mclk2"},  m2,  0);
    check({tag, "_flag2"},  f2,  0);
  endtask

  // Monitor: check nesting every cycle, and compare any queued expectations.
  always @(negedge clk) begin
    exp_t e;
    check("nest10", (c10 >> 1) & ~c10, 0);
    check("nest2",  (c2 >> 1) & ~c2, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("clkp10_e%0d", e.edge_no), c10, e.clkp10);
      check($sformatf("mclk10_e%0d", e.edge_no), m10, e.mclk10);
      check($sformatf("flag10_e%0d", e.edge_no), f10, e.flag10);
      check($sformatf("clkp2_e%0d",  e.edge_no), c2,  e.clkp2);
      check($sformatf("mclk2_e%0d",  e.edge_no), m2,  e.mclk2);
      check($sformatf("flag2_e%0d",  e.edge_no), f2,  e.flag2);
    end
  end

  // Phase 8 timing: it should rise every 200 ns and stay high for 30 ns.
  realtime last_rise = -1.0;
  int      rises     = 0;

  always @(posedge c10[8]) begin
    if (last_rise >= 0.0) check("clkp8_period_ns", 64'($rtoi($realtime - last_rise)), 200);
    last_rise = $realtime;
    rises++;
  end

  always @(negedge c10[8]) begin
    if (last_rise >= 0.0) check("clkp8_high_ns", 64'($rtoi($realtime - last_rise)), 30);
  end

  always @(negedge reset) last_rise = -1.0;

  initial begin
    int budget;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check_all_low("rst_async0");
    @(posedge clk); #1 check_all_low("rst_hold1");
    @(posedge clk); #1 check_all_low("rst_hold2");

    // Release between edges. Then run 48 edges, ending on step 7 for PHASES=10.
    @(negedge clk); reset = 1'b1;
    run_edges(48);

    // Mid-cycle reset at step 7: outputs clear without waiting for a clock edge.
    #7 reset = 1'b0;
    #1 check_all_low("rst_mid_async");
    @(posedge clk); #1 check_all_low("rst_mid_hold1");
    @(posedge clk); #1 check_all_low("rst_mid_hold2");

    @(negedge clk); reset = 1'b1;
    run_edges(25);

    // Give the monitor a bounded number of cycles to drain the queue.
    budget = 5;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("clkp8_rise_count", rises, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
